// File: rtl/arith_pkg.sv
// Shared arithmetic package: FSM state encoding, default width and sign helpers
// used by both the sequential divider and the Booth multiplier.
package arith_pkg;

    localparam int DATA_SIZE_DEFAULT = 8;
    localparam int MAX_WIDTH         = 64;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_t;

    // Callers zero-extend into MAX_WIDTH and truncate the result back to their own width.
    function automatic logic [MAX_WIDTH-1:0] negate(input logic [MAX_WIDTH-1:0] value);
        return ~value + MAX_WIDTH'(1);
    endfunction

    function automatic logic [MAX_WIDTH-1:0] cond_negate(input logic [MAX_WIDTH-1:0] value,
                                                         input logic                 neg);
        return neg ? negate(value) : value;
    endfunction

    function automatic logic [MAX_WIDTH-1:0] abs_value(input logic [MAX_WIDTH-1:0] value,
                                                       input logic                 sign_bit);
        return cond_negate(value, sign_bit);
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration on unsigned magnitudes: shift {rem,quo} left,
// trial-subtract the divisor and keep the difference only when it does not borrow.
module div_restore_step #(
    parameter int DATA_SIZE = 8
) (
    input  logic [DATA_SIZE-1:0] rem,
    input  logic [DATA_SIZE-1:0] quo,
    input  logic [DATA_SIZE-1:0] divisor,
    output logic [DATA_SIZE-1:0] next_rem,
    output logic [DATA_SIZE-1:0] next_quo
);

    logic [DATA_SIZE:0] shifted;
    logic [DATA_SIZE:0] trial;
    logic               borrow;

    // rem < divisor <= 2^(N-1) keeps the shifted value below 2^N, so the top trial bit is a true borrow.
    assign shifted  = {rem, quo[DATA_SIZE-1]};
    assign trial    = shifted - {1'b0, divisor};
    assign borrow   = trial[DATA_SIZE];
    assign next_rem = borrow ? shifted[DATA_SIZE-1:0] : trial[DATA_SIZE-1:0];
    assign next_quo = {quo[DATA_SIZE-2:0], ~borrow};

endmodule

// File: rtl/restoring_divide_fsmd.sv
// Sequential signed restoring divider with the Booth multiplier's start/finish handshake;
// quotient truncates toward zero and the remainder takes the dividend's sign.
module restoring_divide_fsmd
    import arith_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEFAULT
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 enable_i,
    input  logic [DATA_SIZE-1:0] dividend_i,
    input  logic [DATA_SIZE-1:0] divisor_i,
    output logic                 data_valid_o,
    output logic [DATA_SIZE-1:0] quotient_o,
    output logic [DATA_SIZE-1:0] remainder_o,
    output logic                 div_by_zero_o
);

    localparam int              CW         = $clog2(DATA_SIZE + 1);
    localparam logic [CW-1:0]   COUNT_INIT = CW'(DATA_SIZE);

    state_t               state;
    state_t               next_state;
    logic [CW-1:0]        count;
    logic [DATA_SIZE-1:0] rem;
    logic [DATA_SIZE-1:0] quo;
    logic [DATA_SIZE-1:0] mag_d;
    logic [DATA_SIZE-1:0] step_rem;
    logic [DATA_SIZE-1:0] step_quo;
    logic [DATA_SIZE-1:0] mag_n_in;
    logic [DATA_SIZE-1:0] mag_d_in;
    logic [DATA_SIZE-1:0] quo_signed;
    logic [DATA_SIZE-1:0] rem_signed;
    logic                 sign_q;
    logic                 sign_r;
    logic                 divisor_zero;

    assign divisor_zero = (divisor_i == '0);
    assign mag_n_in     = DATA_SIZE'(abs_value(MAX_WIDTH'(dividend_i), dividend_i[DATA_SIZE-1]));
    assign mag_d_in     = DATA_SIZE'(abs_value(MAX_WIDTH'(divisor_i), divisor_i[DATA_SIZE-1]));
    assign quo_signed   = DATA_SIZE'(cond_negate(MAX_WIDTH'(quo), sign_q));
    assign rem_signed   = DATA_SIZE'(cond_negate(MAX_WIDTH'(rem), sign_r));

    div_restore_step #(
        .DATA_SIZE (DATA_SIZE)
    ) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (mag_d),
        .next_rem (step_rem),
        .next_quo (step_quo)
    );

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (enable_i) next_state = divisor_zero ? DONE : CALC;
            CALC: if (count == CW'(1)) next_state = FIX;
            FIX:  next_state = DONE;
            DONE: if (enable_i) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath and registered outputs; quotient/remainder only change on FIX or a zero divisor.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            count         <= '0;
            rem           <= '0;
            quo           <= '0;
            mag_d         <= '0;
            sign_q        <= 1'b0;
            sign_r        <= 1'b0;
            data_valid_o  <= 1'b0;
            quotient_o    <= '0;
            remainder_o   <= '0;
            div_by_zero_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable_i && divisor_zero) begin
                        quotient_o    <= '1;
                        remainder_o   <= dividend_i;
                        div_by_zero_o <= 1'b1;
                        data_valid_o  <= 1'b1;
                    end else if (enable_i) begin
                        quo    <= mag_n_in;
                        mag_d  <= mag_d_in;
                        rem    <= '0;
                        count  <= COUNT_INIT;
                        sign_q <= dividend_i[DATA_SIZE-1] ^ divisor_i[DATA_SIZE-1];
                        sign_r <= dividend_i[DATA_SIZE-1];
                    end
                end
                CALC: begin
                    rem   <= step_rem;
                    quo   <= step_quo;
                    count <= count - CW'(1);
                end
                FIX: begin
                    quotient_o   <= quo_signed;
                    remainder_o  <= rem_signed;
                    data_valid_o <= 1'b1;
                end
                DONE: begin
                    if (enable_i) begin
                        data_valid_o  <= 1'b0;
                        div_by_zero_o <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_restoring_divide_fsmd.sv
// Self-checking bench for restoring_divide_fsmd: directed sign/boundary cases,
// divide-by-zero, reset mid-operation and a randomized back-to-back run against C-style / and %.
module tb_restoring_divide_fsmd;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] dividend = '0;
    logic [7:0] divisor = '0;
    logic       valid;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       dbz;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    restoring_divide_fsmd #(
        .DATA_SIZE (8)
    ) dut (
        .clk_i         (clk),
        .reset_ni      (rst_n),
        .enable_i      (enable),
        .dividend_i    (dividend),
        .divisor_i     (divisor),
        .data_valid_o  (valid),
        .quotient_o    (quotient),
        .remainder_o   (remainder),
        .div_by_zero_o (dbz)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents operands with a one-cycle enable pulse; returns just after the sampling edge.
    task automatic start_op(input logic [7:0] n, input logic [7:0] d);
        dividend = n;
        divisor  = d;
        enable   = 1'b1;
        tick();
        enable   = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output int edges);
        edges = 1;
        while (valid !== 1'b1 && edges < limit) begin
            tick();
            edges++;
        end
    endtask

    task automatic release_op();
        enable = 1'b1;
        tick();
        enable = 1'b0;
    endtask

    // Reference: C-style truncating division computed on plain integers, wrapped to 8 bits.
    function automatic void ref_div(input logic [7:0] n, input logic [7:0] d,
                                    output logic [7:0] q, output logic [7:0] r);
        int ni;
        int di;
        int qi;
        int ri;
        ni = int'($signed(n));
        di = int'($signed(d));
        qi = ni / di;
        ri = ni % di;
        q  = qi[7:0];
        r  = ri[7:0];
    endfunction

    task automatic test_reset();
        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", valid); end
        checks++;
        if (quotient !== 8'h00) begin errors++; $display("[TB] FAIL reset_quotient: got %h expected 00", quotient); end
        checks++;
        if (remainder !== 8'h00) begin errors++; $display("[TB] FAIL reset_remainder: got %h expected 00", remainder); end
        checks++;
        if (dbz !== 1'b0) begin errors++; $display("[TB] FAIL reset_dbz: got %b expected 0", dbz); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_signed_quotients();
        logic [7:0] tn [6] = '{8'd100, 8'h9C, 8'd100, 8'h80, 8'h80, 8'h00};
        logic [7:0] td [6] = '{8'd7,   8'd7,  8'hF9,  8'hFF, 8'h01, 8'h05};
        logic [7:0] tq [6] = '{8'h0E,  8'hF2, 8'hF2,  8'h80, 8'h80, 8'h00};
        logic [7:0] tr [6] = '{8'h02,  8'hFE, 8'h02,  8'h00, 8'h00, 8'h00};
        int edges;
        for (int i = 0; i < 6; i++) begin
            start_op(tn[i], td[i]);
            wait_valid(20, edges);
            checks++;
            if (edges !== 10 || valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL latency_%0d: got %0d edges valid=%b expected 10 edges", i, edges, valid);
            end
            checks++;
            if (quotient !== tq[i]) begin errors++; $display("[TB] FAIL quotient_%0d: got %h expected %h", i, quotient, tq[i]); end
            checks++;
            if (remainder !== tr[i]) begin errors++; $display("[TB] FAIL remainder_%0d: got %h expected %h", i, remainder, tr[i]); end
            checks++;
            if (dbz !== 1'b0) begin errors++; $display("[TB] FAIL dbz_%0d: got %b expected 0", i, dbz); end
            release_op();
            checks++;
            if (valid !== 1'b0 || quotient !== tq[i]) begin
                errors++;
                $display("[TB] FAIL release_%0d: got valid=%b q=%h expected valid=0 q=%h", i, valid, quotient, tq[i]);
            end
        end
    endtask

    task automatic test_div_by_zero();
        int edges;
        start_op(8'd5, 8'd0);
        wait_valid(5, edges);
        checks++;
        if (edges !== 1 || valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL dbz_latency: got %0d edges valid=%b expected 1 edge", edges, valid);
        end
        checks++;
        if (dbz !== 1'b1) begin errors++; $display("[TB] FAIL dbz_flag: got %b expected 1", dbz); end
        checks++;
        if (quotient !== 8'hFF) begin errors++; $display("[TB] FAIL dbz_quotient: got %h expected ff", quotient); end
        checks++;
        if (remainder !== 8'h05) begin errors++; $display("[TB] FAIL dbz_remainder: got %h expected 05", remainder); end
        release_op();
        checks++;
        if (dbz !== 1'b0 || valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL dbz_release: got dbz=%b valid=%b expected 0 0", dbz, valid);
        end
    endtask

    task automatic test_ignore_and_reset();
        int edges;
        start_op(8'd100, 8'd7);
        edges = 1;
        repeat (3) begin tick(); edges++; end
        dividend = 8'd50;
        divisor  = 8'd0;
        enable   = 1'b1;
        tick();
        edges++;
        enable   = 1'b0;
        while (valid !== 1'b1 && edges < 20) begin tick(); edges++; end
        checks++;
        if (edges !== 10) begin errors++; $display("[TB] FAIL ignore_latency: got %0d expected 10", edges); end
        checks++;
        if (quotient !== 8'h0E || remainder !== 8'h02 || dbz !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ignore_result: got q=%h r=%h dbz=%b expected 0e 02 0", quotient, remainder, dbz);
        end
        release_op();

        start_op(8'd100, 8'd7);
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (quotient !== 8'h00 || remainder !== 8'h00 || valid !== 1'b0 || dbz !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: got q=%h r=%h valid=%b dbz=%b expected all 0", quotient, remainder, valid, dbz);
        end
        tick();
        rst_n = 1'b1;
        repeat (12) tick();
        checks++;
        if (valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_discard: got valid=%b expected 0", valid); end

        start_op(8'd50, 8'd3);
        wait_valid(20, edges);
        checks++;
        if (edges !== 10 || quotient !== 8'h10 || remainder !== 8'h02) begin
            errors++;
            $display("[TB] FAIL after_reset: got edges=%0d q=%h r=%h expected 10 10 02", edges, quotient, remainder);
        end
        release_op();
    endtask

    task automatic pick_operands(output logic [7:0] n, output logic [7:0] d);
        n = 8'($urandom);
        d = 8'($urandom);
        if ($urandom_range(0, 15) == 0) n = 8'h80;
        if ($urandom_range(0, 15) == 0) d = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h01;
        if (d == 8'h00) d = 8'h03;
    endtask

    task automatic test_back_to_back();
        logic [7:0] n;
        logic [7:0] d;
        logic [7:0] eq;
        logic [7:0] er;
        logic [7:0] recon;
        int         edges;
        int         ra;
        int         da;
        pick_operands(n, d);
        dividend = n;
        divisor  = d;
        enable   = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            edges = 0;
            while (valid !== 1'b1 && edges < 30) begin tick(); edges++; end
            checks++;
            if (valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL b2b_timeout_%0d: got valid=%b expected 1 within 30 edges", i, valid);
                break;
            end
            ref_div(n, d, eq, er);
            checks++;
            if (quotient !== eq) begin errors++; $display("[TB] FAIL b2b_quotient_%0d: %h/%h got %h expected %h", i, n, d, quotient, eq); end
            checks++;
            if (remainder !== er) begin errors++; $display("[TB] FAIL b2b_remainder_%0d: %h/%h got %h expected %h", i, n, d, remainder, er); end
            recon = quotient * d + remainder;
            ra = int'($signed(remainder));
            da = int'($signed(d));
            if (ra < 0) ra = -ra;
            if (da < 0) da = -da;
            checks++;
            if (recon !== n || ra >= da || dbz !== 1'b0) begin
                errors++;
                $display("[TB] FAIL b2b_invariant_%0d: got q*d+r=%h |r|=%0d dbz=%b expected %h |r|<%0d dbz=0", i, recon, ra, dbz, n, da);
            end
            pick_operands(n, d);
            dividend = n;
            divisor  = d;
            edges = 0;
            while (valid !== 1'b0 && edges < 5) begin tick(); edges++; end
            checks++;
            if (valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL b2b_release_%0d: got valid=%b expected 0", i, valid);
                break;
            end
        end
        enable = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_signed_quotients();
        test_div_by_zero();
        test_ignore_and_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
